// File: rtl/word_reader_if.sv
// Key-word buffer bus: key writes and control in, keyed readout stream and status out.
// Latency: wires only, no storage.
// Backpressure: rd_valid/rd_ready handshake on the readout side; the write side has none.
interface word_reader_if #(
    parameter int KEY_W = 4
);
    logic             wr_valid;
    logic [KEY_W-1:0] wr_key;
    logic             clear;
    logic             start;
    logic             rd_ready;
    logic             rd_valid;
    logic [KEY_W-1:0] rd_key;
    logic [2:0]       rd_index;
    logic [2:0]       len;
    logic             busy;
    logic             done;

    // Producer/consumer side that drives keys and controls, and watches the readout.
    modport master (
        output wr_valid, wr_key, clear, start, rd_ready,
        input  rd_valid, rd_key, rd_index, len, busy, done
    );

    // The word_reader itself.
    modport slave (
        input  wr_valid, wr_key, clear, start, rd_ready,
        output rd_valid, rd_key, rd_index, len, busy, done
    );
endinterface

// File: rtl/word_reader.sv
// Stores up to 7 key codes typed in IDLE and replays them as a valid/ready stream on start.
// Latency: a write lands on the strobe edge; the first beat appears one cycle after start.
// Backpressure: rd_ready=0 stalls readout with rd_key/rd_index held; writes are never stalled.
// Build option: define WORD_READER_REVERSE_EN to read slots from len-1 down to 0.
module word_reader #(
    parameter int KEY_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    word_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LEN_MAX = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       len_q,   len_d;
    logic [2:0]       idx_q,   idx_d;
    logic [KEY_W-1:0] buf_q [0:6];
    logic [KEY_W-1:0] buf_d [0:6];

    logic [2:0]       first_idx;
    logic [2:0]       next_idx;
    logic             last_beat;

    // Readout direction: where a word starts, how the index steps, and which slot ends it.
`ifdef WORD_READER_REVERSE_EN
    assign first_idx = len_q - 3'd1;
    assign next_idx  = idx_q - 3'd1;
    assign last_beat = (idx_q == 3'd0);
`else
    assign first_idx = 3'd0;
    assign next_idx  = idx_q + 3'd1;
    assign last_beat = (idx_q == (len_q - 3'd1));
`endif

    // Next-state logic: clear beats start beats write in IDLE; SEND/DONE ignore writes and start.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    len_d = 3'd0;
                end else if (bus.start) begin
                    // Empty word skips SEND so done still pulses with no beats.
                    if (len_q != 3'd0) begin
                        state_d = ST_SEND;
                        idx_d   = first_idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (bus.wr_valid && (len_q != LEN_MAX)) begin
                    buf_d[len_q] = bus.wr_key;
                    len_d        = len_q + 3'd1;
                end
            end
            ST_SEND: begin
                // Abort wins; a beat accepted on the same edge has already been delivered.
                if (bus.clear) begin
                    state_d = ST_IDLE;
                    len_d   = 3'd0;
                    idx_d   = 3'd0;
                end else if (bus.rd_ready) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = next_idx;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Key storage needs no reset: only slots below len are ever read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Outputs decode from state only, so reset clears them without waiting for a clock.
    always_comb begin
        bus.rd_valid = (state_q == ST_SEND);
        bus.rd_key   = '0;
        bus.rd_index = 3'd0;
        if (state_q == ST_SEND) begin
            bus.rd_key   = buf_q[idx_q];
            bus.rd_index = idx_q;
        end
        bus.len  = len_q;
        bus.busy = (state_q != ST_IDLE);
        bus.done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_word_reader.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based word model.
// Latency: inputs driven 1 time unit after a rising edge; outputs checked 1 unit after the next.
// Backpressure: rd_ready driven directly by the bench per cycle.
module tb_word_reader;

`ifdef WORD_READER_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic clk;
    logic reset;

    word_reader_if #(.KEY_W(4)) bus ();

    word_reader #(.KEY_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the stored word, readout phase (0 idle, 1 sending, 2 done), beats delivered.
    logic [3:0] word [$];
    int         phase = 0;
    int         beats = 0;
    logic [3:0] got  [$];
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int         n;
        int         ix;
        logic [3:0] k;
        n  = word.size();
        ix = 0;
        k  = 4'd0;
        if (phase == 1) begin
            ix = REV ? (n - 1 - beats) : beats;
            k  = word[ix];
        end
        chk("rd_valid", {31'd0, bus.rd_valid}, (phase == 1) ? 32'd1 : 32'd0);
        chk("rd_key",   {28'd0, bus.rd_key},   {28'd0, k});
        chk("rd_index", {29'd0, bus.rd_index}, ix);
        chk("len",      {29'd0, bus.len},      n);
        chk("busy",     {31'd0, bus.busy},     (phase != 0) ? 32'd1 : 32'd0);
        chk("done",     {31'd0, bus.done},     (phase == 2) ? 32'd1 : 32'd0);
    endtask

    task automatic model_step(input logic wr, input logic [3:0] key, input logic clr,
                              input logic st, input logic rdy);
        case (phase)
            0: begin
                if (clr) word.delete();
                else if (st) begin
                    phase = (word.size() > 0) ? 1 : 2;
                    beats = 0;
                end else if (wr && word.size() < 7) word.push_back(key);
            end
            1: begin
                if (clr) begin
                    word.delete();
                    phase = 0;
                end else if (rdy) begin
                    beats++;
                    if (beats == word.size()) phase = 2;
                end
            end
            default: phase = 0;
        endcase
    endtask

    task automatic cycle(input logic wr, input logic [3:0] key, input logic clr,
                         input logic st, input logic rdy);
        bus.wr_valid = wr;
        bus.wr_key   = key;
        bus.clear    = clr;
        bus.start    = st;
        bus.rd_ready = rdy;
        if (bus.rd_valid && rdy) got.push_back(bus.rd_key);
        model_step(wr, key, clr, st, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic add_exp(input logic [3:0] k);
        if (REV) exp_q.push_front(k);
        else     exp_q.push_back(k);
    endtask

    task automatic expect_seq(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_key"}, {28'd0, got[i]}, {28'd0, exp_q[i]});
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_key   = 4'd0;
        bus.clear    = 1'b0;
        bus.start    = 1'b0;
        bus.rd_ready = 1'b0;
        #2;
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_done",     {31'd0, bus.done},     32'd0);
        chk("rst_len",      {29'd0, bus.len},      32'd0);
        chk("rst_rd_key",   {28'd0, bus.rd_key},   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();

        // Keys 3,5,9 read back-to-back with rd_ready held high.
        cycle(1, 4'd3, 0, 0, 0);
        cycle(1, 4'd5, 0, 0, 0);
        cycle(1, 4'd9, 0, 0, 0);
        got.delete();
        cycle(0, 4'd0, 0, 1, 1);
        chk("s1_first_index", {29'd0, bus.rd_index}, REV ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("s1_no_bubble", {31'd0, bus.rd_valid}, 32'd1);
            cycle(0, 4'd0, 0, 0, 1);
        end
        chk("s1_done", {31'd0, bus.done}, 32'd1);
        exp_q.delete();
        add_exp(4'd3); add_exp(4'd5); add_exp(4'd9);
        expect_seq("s1");
        cycle(0, 4'd0, 0, 0, 1);
        chk("s1_len_kept", {29'd0, bus.len}, 32'd3);

        // Eight writes saturate at seven; the eighth key is dropped.
        cycle(0, 4'd0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) cycle(1, 4'(k), 0, 0, 0);
        chk("s2_len_sat", {29'd0, bus.len}, 32'd7);
        got.delete();
        cycle(0, 4'd0, 0, 1, 1);
        for (int i = 0; i < 7; i++) cycle(0, 4'd0, 0, 0, 1);
        exp_q.delete();
        for (int k = 1; k <= 7; k++) add_exp(4'(k));
        expect_seq("s2");
        cycle(0, 4'd0, 0, 0, 0);

        // Two-key word with a stalling consumer.
        cycle(0, 4'd0, 1, 0, 0);
        cycle(1, 4'hA, 0, 0, 0);
        cycle(1, 4'hB, 0, 0, 0);
        got.delete();
        cycle(0, 4'd0, 0, 1, 0);
        cycle(0, 4'd0, 0, 0, 0);
        cycle(0, 4'd0, 0, 0, 0);
        cycle(0, 4'd0, 0, 0, 1);
        cycle(0, 4'd0, 0, 0, 0);
        cycle(0, 4'd0, 0, 0, 1);
        chk("s3_done", {31'd0, bus.done}, 32'd1);
        exp_q.delete();
        add_exp(4'hA); add_exp(4'hB);
        expect_seq("s3");
        cycle(0, 4'd0, 0, 0, 0);

        // Abort after two of four beats, then start on the emptied word.
        cycle(0, 4'd0, 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, 4'(k + 4), 0, 0, 0);
        cycle(0, 4'd0, 0, 1, 1);
        cycle(0, 4'd0, 0, 0, 1);
        cycle(0, 4'd0, 0, 0, 1);
        cycle(0, 4'd0, 1, 0, 0);
        chk("s4_abort_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("s4_abort_len",   {29'd0, bus.len},      32'd0);
        chk("s4_abort_done",  {31'd0, bus.done},     32'd0);
        cycle(0, 4'd0, 0, 0, 0);
        got.delete();
        cycle(0, 4'd0, 0, 1, 1);
        chk("s4_empty_done", {31'd0, bus.done}, 32'd1);
        cycle(0, 4'd0, 0, 0, 1);
        chk("s4_empty_beats", got.size(), 32'd0);

        // Same-cycle priority in IDLE.
        cycle(1, 4'd2, 0, 0, 0);
        cycle(1, 4'd3, 1, 0, 0);
        chk("s5_clear_wins", {29'd0, bus.len}, 32'd0);
        cycle(1, 4'd6, 0, 0, 0);
        got.delete();
        cycle(1, 4'd7, 0, 1, 1);
        chk("s5_start_len", {29'd0, bus.len}, 32'd1);
        cycle(0, 4'd0, 0, 0, 1);
        exp_q.delete();
        add_exp(4'd6);
        expect_seq("s5");
        cycle(0, 4'd0, 0, 0, 0);

        // Asynchronous reset between edges during SEND.
        cycle(1, 4'd1, 0, 0, 0);
        cycle(1, 4'd2, 0, 0, 0);
        cycle(0, 4'd0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("s6_busy",     {31'd0, bus.busy},     32'd0);
        chk("s6_len",      {29'd0, bus.len},      32'd0);
        word.delete();
        phase = 0;
        beats = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
        cycle(0, 4'd0, 0, 0, 1);
        cycle(0, 4'd0, 0, 0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
